if_wishbone_bus_if: RTL and testbench

//  Instruction-side Wishbone B3 classic master between the PC register and the IF/ID stage.

---
 rtl/if_wishbone_bus_if_pkg.sv | 14 +
 rtl/if_wishbone_bus_if_if.sv | 14 +
 rtl/if_wishbone_bus_if.sv | 88 ++++++++
 tb/tb_if_wishbone_bus_if.sv | 196 +++++++++++++++++++
 4 files changed

// File: rtl/if_wishbone_bus_if_pkg.sv
// if_wishbone_bus_if_pkg: shared widths, constants and FSM states for the Wishbone fetch master
package if_wishbone_bus_if_pkg;
  localparam int REG_BUS = 32;
  localparam int INST_ADDR_BUS = 32;
  localparam logic [REG_BUS-1:0] ZERO_WORD = '0;
  localparam logic NO_STOP = 1'b0;
  localparam logic STOP = 1'b1;
  localparam logic RST_ENABLE = 1'b1;
  typedef enum logic [1:0] {
    WB_IDLE = 2'd0,
    WB_BUSY = 2'd1,
    WB_WAIT_FOR_STALL = 2'd2
  } wb_state_e;
endpackage

// File: rtl/if_wishbone_bus_if_if.sv
// if_wishbone_bus_if_if: Wishbone B3 classic bus bundle with master/slave views
interface if_wishbone_bus_if_if;
  import if_wishbone_bus_if_pkg::*;
  logic [INST_ADDR_BUS-1:0] adr;
  logic [REG_BUS-1:0] dat_r;
  logic ack;
  logic err;
  logic cyc;
  logic stb;
  logic we;
  logic [3:0] sel;
  modport master (output adr, cyc, stb, we, sel, input dat_r, ack, err);
  modport slave (input adr, cyc, stb, we, sel, output dat_r, ack, err);
endinterface

// File: rtl/if_wishbone_bus_if.sv
// if_wishbone_bus_if: instruction-side Wishbone master turning {pc, ce} into single-beat reads
module if_wishbone_bus_if
  import if_wishbone_bus_if_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 16,
  parameter logic [REG_BUS-1:0] NOP_WORD = ZERO_WORD
) (
  input  logic clk,
  input  logic rst,
  input  logic [5:0] stall,
  input  logic flush,
  input  logic cpu_ce_i,
  input  logic [INST_ADDR_BUS-1:0] cpu_addr_i,
  output logic [REG_BUS-1:0] cpu_data_o,
  output logic stallreq_o,
  output logic bus_err_o,
  if_wishbone_bus_if_if.master wb
);
  localparam int TW = $clog2(TIMEOUT_CYCLES);
  wb_state_e state_q, state_d;
  logic [INST_ADDR_BUS-1:0] adr_q, adr_d;
  logic [REG_BUS-1:0] buf_q, buf_d;
  logic [TW-1:0] timer_q, timer_d;
  logic err_q, err_d;
  logic busy, stalled, timeout;
  assign busy = state_q == WB_BUSY;
  assign stalled = |stall;
  assign timeout = timer_q == TW'(TIMEOUT_CYCLES - 1);
  always_ff @(posedge clk or posedge rst)
    if (rst == RST_ENABLE) begin
      state_q <= WB_IDLE;
      adr_q <= '0;
      buf_q <= NOP_WORD;
      timer_q <= '0;
      err_q <= 1'b0;
    end else begin
      state_q <= state_d;
      adr_q <= adr_d;
      buf_q <= buf_d;
      timer_q <= timer_d;
      err_q <= err_d;
    end
  // flush outranks ack, and ack outranks err/timeout so a good word is never discarded
  always_comb begin
    state_d = state_q;
    adr_d = adr_q;
    buf_d = buf_q;
    timer_d = timer_q;
    err_d = 1'b0;
    case (state_q)
      WB_IDLE:
        if (cpu_ce_i && !flush) begin
          state_d = WB_BUSY;
          adr_d = cpu_addr_i;
          timer_d = '0;
        end
      WB_BUSY:
        if (flush) begin
          state_d = WB_IDLE;
          buf_d = NOP_WORD;
        end else if (wb.ack) begin
          state_d = stalled ? WB_WAIT_FOR_STALL : WB_IDLE;
          buf_d = wb.dat_r;
        end else if (wb.err || timeout) begin
          state_d = stalled ? WB_WAIT_FOR_STALL : WB_IDLE;
          buf_d = NOP_WORD;
          err_d = 1'b1;
        end else
          timer_d = (timer_q == '1) ? timer_q : timer_q + TW'(1);
      WB_WAIT_FOR_STALL:
        if (flush || !stalled) begin
          state_d = WB_IDLE;
          buf_d = flush ? NOP_WORD : buf_q;
        end
      default: state_d = WB_IDLE;
    endcase
  end
  assign wb.cyc = busy;
  assign wb.stb = busy;
  assign wb.we = 1'b0;
  assign wb.sel = busy ? 4'hF : 4'h0;
  assign wb.adr = adr_q;
  assign bus_err_o = err_q;
  assign stallreq_o = ((state_q == WB_IDLE && cpu_ce_i && !flush) ||
                       (busy && !wb.ack && !wb.err && !timeout && !flush)) ? STOP : NO_STOP;
  assign cpu_data_o = (busy && wb.ack) ? wb.dat_r :
                      (state_q == WB_WAIT_FOR_STALL) ? buf_q : NOP_WORD;
endmodule

// File: tb/tb_if_wishbone_bus_if.sv
// tb_if_wishbone_bus_if: directed vector table, timeout/reset sequences and randomized model check
module tb_if_wishbone_bus_if;
  localparam int TO = 16;
  localparam logic [31:0] P = 32'h3000_0000;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic [5:0] stall = '0;
  logic flush = 1'b0;
  logic ce = 1'b0;
  logic [31:0] addr = '0;
  logic [31:0] cpu_data;
  logic stallreq, bus_err;
  int checks = 0;
  int errors = 0;
  if_wishbone_bus_if_if bus ();
  if_wishbone_bus_if #(.TIMEOUT_CYCLES(TO), .NOP_WORD(32'h0)) dut (
    .clk(clk), .rst(rst), .stall(stall), .flush(flush), .cpu_ce_i(ce), .cpu_addr_i(addr),
    .cpu_data_o(cpu_data), .stallreq_o(stallreq), .bus_err_o(bus_err), .wb(bus)
  );
  always #5 clk = ~clk;
  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1);
  end
  typedef struct {
    logic [3:0] in_f;
    logic [31:0] addr;
    logic [5:0] stall;
    logic [31:0] dat;
    logic [2:0] ex_f;
    logic [31:0] ex_adr;
    logic [31:0] ex_data;
  } vec_t;
  vec_t vecs[19];
  logic m_busy, m_hold, m_errp;
  int m_age;
  logic [31:0] m_adr, m_word;
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask
  task automatic drive(input logic c, input logic [31:0] a, input logic [5:0] s, input logic f,
                       input logic k, input logic e, input logic [31:0] d);
    @(negedge clk);
    ce = c;
    addr = a;
    stall = s;
    flush = f;
    bus.ack = k;
    bus.err = e;
    bus.dat_r = d;
    #1;
  endtask
  task automatic idle();
    drive(1'b0, 32'h0, 6'd0, 1'b0, 1'b0, 1'b0, 32'h0);
  endtask
  task automatic model_cycle();
    logic to, sreq, errp;
    logic [31:0] exp_data;
    to = m_busy && m_age >= TO - 1;
    sreq = (!m_busy && !m_hold && ce && !flush) || (m_busy && !bus.ack && !bus.err && !to && !flush);
    exp_data = (m_busy && bus.ack) ? bus.dat_r : m_hold ? m_word : 32'h0;
    chk("rnd_cyc", {31'h0, bus.cyc}, {31'h0, m_busy});
    chk("rnd_stb", {31'h0, bus.stb}, {31'h0, m_busy});
    chk("rnd_sel", {28'h0, bus.sel}, m_busy ? 32'hF : 32'h0);
    chk("rnd_adr", bus.adr, m_adr);
    chk("rnd_stallreq", {31'h0, stallreq}, {31'h0, sreq});
    chk("rnd_data", cpu_data, exp_data);
    chk("rnd_bus_err", {31'h0, bus_err}, {31'h0, m_errp});
    errp = 1'b0;
    if (m_busy) begin
      if (flush) m_busy = 1'b0;
      else if (bus.ack) begin
        m_busy = 1'b0;
        m_hold = stall != 0;
        m_word = bus.dat_r;
      end else if (bus.err || to) begin
        m_busy = 1'b0;
        m_hold = stall != 0;
        m_word = 32'h0;
        errp = 1'b1;
      end else m_age++;
    end else if (m_hold) begin
      if (flush || stall == 0) m_hold = 1'b0;
    end else if (ce && !flush) begin
      m_busy = 1'b1;
      m_adr = addr;
      m_age = 0;
    end
    m_errp = errp;
  endtask
  initial begin
    int n;
    logic done, last_sreq;
    bus.ack = 1'b0;
    bus.err = 1'b0;
    bus.dat_r = '0;
    vecs[0]  = '{4'b1000, P,        6'd0, 32'h0,         3'b010, 32'h0,    32'h0};
    vecs[1]  = '{4'b1000, P,        6'd0, 32'h0,         3'b110, P,        32'h0};
    vecs[2]  = '{4'b0010, P,        6'd0, 32'h3401_1100, 3'b100, P,        32'h3401_1100};
    vecs[3]  = '{4'b0000, P,        6'd0, 32'h0,         3'b000, P,        32'h0};
    vecs[4]  = '{4'b1000, P + 4,    6'd0, 32'h0,         3'b010, P,        32'h0};
    vecs[5]  = '{4'b1010, P + 4,    6'd3, 32'hDEAD_BEEF, 3'b100, P + 4,    32'hDEAD_BEEF};
    vecs[6]  = '{4'b1000, P + 8,    6'd3, 32'h0,         3'b000, P + 4,    32'hDEAD_BEEF};
    vecs[7]  = '{4'b1000, P + 8,    6'd3, 32'h0,         3'b000, P + 4,    32'hDEAD_BEEF};
    vecs[8]  = '{4'b1000, P + 8,    6'd0, 32'h0,         3'b000, P + 4,    32'hDEAD_BEEF};
    vecs[9]  = '{4'b1000, P + 8,    6'd0, 32'h0,         3'b010, P + 4,    32'h0};
    vecs[10] = '{4'b1100, P + 12,   6'd0, 32'h0,         3'b100, P + 8,    32'h0};
    vecs[11] = '{4'b1010, P + 12,   6'd0, 32'h1111_1111, 3'b010, P + 8,    32'h0};
    vecs[12] = '{4'b0000, P + 12,   6'd0, 32'h0,         3'b110, P + 12,   32'h0};
    vecs[13] = '{4'b0011, P + 12,   6'd0, 32'hCAFE_F00D, 3'b100, P + 12,   32'hCAFE_F00D};
    vecs[14] = '{4'b0000, P + 12,   6'd0, 32'h0,         3'b000, P + 12,   32'h0};
    vecs[15] = '{4'b1000, P + 16,   6'd0, 32'h0,         3'b010, P + 12,   32'h0};
    vecs[16] = '{4'b0001, P + 16,   6'd0, 32'h0,         3'b100, P + 16,   32'h0};
    vecs[17] = '{4'b0000, P + 16,   6'd0, 32'h0,         3'b001, P + 16,   32'h0};
    vecs[18] = '{4'b0000, P + 16,   6'd0, 32'h0,         3'b000, P + 16,   32'h0};
    #2;
    chk("reset_cyc", {31'h0, bus.cyc}, 32'h0);
    chk("reset_adr", bus.adr, 32'h0);
    chk("reset_sel", {28'h0, bus.sel}, 32'h0);
    chk("reset_we", {31'h0, bus.we}, 32'h0);
    chk("reset_bus_err", {31'h0, bus_err}, 32'h0);
    chk("reset_data", cpu_data, 32'h0);
    @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < 19; i++) begin
      drive(vecs[i].in_f[3], vecs[i].addr, vecs[i].stall, vecs[i].in_f[2], vecs[i].in_f[1],
            vecs[i].in_f[0], vecs[i].dat);
      chk($sformatf("v%0d_cyc", i), {31'h0, bus.cyc}, {31'h0, vecs[i].ex_f[2]});
      chk($sformatf("v%0d_stb", i), {31'h0, bus.stb}, {31'h0, vecs[i].ex_f[2]});
      chk($sformatf("v%0d_stallreq", i), {31'h0, stallreq}, {31'h0, vecs[i].ex_f[1]});
      chk($sformatf("v%0d_bus_err", i), {31'h0, bus_err}, {31'h0, vecs[i].ex_f[0]});
      chk($sformatf("v%0d_adr", i), bus.adr, vecs[i].ex_adr);
      chk($sformatf("v%0d_data", i), cpu_data, vecs[i].ex_data);
    end
    drive(1'b1, P + 32, 6'd0, 1'b0, 1'b0, 1'b0, 32'h0);
    chk("to_start_stallreq", {31'h0, stallreq}, 32'h1);
    n = 0;
    done = 1'b0;
    last_sreq = 1'b1;
    for (int i = 0; i < 40 && !done; i++) begin
      idle();
      if (bus.cyc) begin
        n++;
        last_sreq = stallreq;
      end else done = 1'b1;
    end
    chk("to_busy_cycles", n, TO);
    chk("to_last_stallreq", {31'h0, last_sreq}, 32'h0);
    chk("to_err_pulse", {31'h0, bus_err}, 32'h1);
    chk("to_data", cpu_data, 32'h0);
    idle();
    chk("to_err_clear", {31'h0, bus_err}, 32'h0);
    drive(1'b1, P + 64, 6'd0, 1'b0, 1'b0, 1'b0, 32'h0);
    idle();
    chk("rst_pre_cyc", {31'h0, bus.cyc}, 32'h1);
    @(posedge clk);
    #3;
    rst = 1'b1;
    #1;
    chk("rst_async_cyc", {31'h0, bus.cyc}, 32'h0);
    chk("rst_async_stb", {31'h0, bus.stb}, 32'h0);
    chk("rst_async_sel", {28'h0, bus.sel}, 32'h0);
    chk("rst_async_data", cpu_data, 32'h0);
    @(negedge clk);
    rst = 1'b0;
    idle();
    chk("rst_no_err", {31'h0, bus_err}, 32'h0);
    chk("rst_idle_cyc", {31'h0, bus.cyc}, 32'h0);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    m_busy = 1'b0;
    m_hold = 1'b0;
    m_errp = 1'b0;
    m_age = 0;
    m_adr = 32'h0;
    m_word = 32'h0;
    for (int c = 0; c < 3000; c++) begin
      int ackp;
      ackp = ((c / 200) % 4 == 3) ? 0 : 30;
      drive($urandom_range(0, 9) < 7, $urandom & 32'hFFFF_FFFC,
            ($urandom_range(0, 1) == 1) ? 6'd0 : 6'($urandom),
            $urandom_range(0, 19) == 0, $urandom_range(0, 99) < ackp,
            $urandom_range(0, 24) == 0, $urandom);
      model_cycle();
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
